// File: rtl/tartaruga_pkg.sv
// Shared types for the rename scoreboard: register/tag/data widths and per-register state.
// Latency: n/a (types only).
// Backpressure: n/a.
package tartaruga_pkg;

    // Widest ROB tag any instantiation may use; narrower tags are zero-extended
    // into rob_idx_t so one entry struct serves every ROB_IDX_W <= this value.
    localparam int ROB_IDX_MAX_W = 8;

    typedef logic [ROB_IDX_MAX_W-1:0] rob_idx_t;
    typedef logic [4:0]               reg_addr_t;
    typedef logic [31:0]              bus32_t;

    typedef struct packed {
        logic     busy;   // a speculative producer owns this register
        logic     done;   // producer has written back; value is valid
        rob_idx_t tag;    // ROB entry of the youngest producer
        bus32_t   value;  // written-back result awaiting commit
    } sb_entry_t;

endpackage

// File: rtl/rename_sb_fwd_mux.sv
// Priority operand select for one source: regfile, stored result, or lowest-index matching bypass.
// Latency: purely combinational, zero cycles.
// Backpressure: none; resolved_o low tells decode to stall.
// Ports: entry_i (scoreboard state of the source register), rf_data_i (regfile read),
//        byp_valid_i/byp_tag_i/byp_data_i (flattened bypass ports, port 0 youngest),
//        data_o (operand), resolved_o (operand is valid this cycle).
module rename_sb_fwd_mux
    import tartaruga_pkg::*;
#(
    parameter int NUM_BYPASS = 2,
    parameter int ROB_IDX_W  = 3
) (
    input  sb_entry_t                        entry_i,
    input  bus32_t                           rf_data_i,
    input  logic [NUM_BYPASS-1:0]            byp_valid_i,
    input  logic [NUM_BYPASS*ROB_IDX_W-1:0]  byp_tag_i,
    input  logic [NUM_BYPASS*32-1:0]         byp_data_i,
    output bus32_t                           data_o,
    output logic                             resolved_o
);

    logic   byp_hit;
    bus32_t byp_dat;

    always_comb begin
        byp_hit = 1'b0;
        byp_dat = '0;
        // Walk from the oldest port down so the lowest index match is the last write.
        for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
            if (byp_valid_i[i] &&
                entry_i.tag == rob_idx_t'(byp_tag_i[i*ROB_IDX_W +: ROB_IDX_W])) begin
                byp_hit = 1'b1;
                byp_dat = byp_data_i[i*32 +: 32];
            end
        end

        data_o     = rf_data_i;
        resolved_o = 1'b1;
        if (entry_i.busy) begin
            if (entry_i.done) begin
                data_o = entry_i.value;
            end else begin
                data_o     = byp_dat;
                resolved_o = byp_hit;
            end
        end
    end

endmodule

// File: rtl/rename_scoreboard.sv
// Register rename scoreboard: tracks in-flight producers per register and resolves decode operands.
// Latency: operand lookup is combinational; alloc/wb/commit/flush take effect on the next clk_i edge.
// Backpressure: operands_ready_o low means decode must stall; no input is ever refused.
// Ports: flush_i, alloc_*_i (decode issue), rs*_addr_i / rf_rs*_data_i (source lookup),
//        byp_*_i (bypass network), wb_*_i (writeback), commit_*_i (in-order retire),
//        rs*_data_o / operands_ready_o (resolved operands).
// Optional: define RENAME_SB_PERF_EN to add stall_cnt_o, a saturating count of stalled issue cycles.
module rename_scoreboard
    import tartaruga_pkg::*;
#(
    parameter int NUM_BYPASS = 2,
    parameter int ROB_IDX_W  = 3,   // must not exceed ROB_IDX_MAX_W
    parameter int NUM_REGS   = 32
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             flush_i,
    input  logic                             alloc_valid_i,
    input  logic                             alloc_we_i,
    input  logic [4:0]                       alloc_rd_i,
    input  logic [ROB_IDX_W-1:0]             alloc_tag_i,
    input  logic [4:0]                       rs1_addr_i,
    input  logic [4:0]                       rs2_addr_i,
    input  logic [31:0]                      rf_rs1_data_i,
    input  logic [31:0]                      rf_rs2_data_i,
    input  logic [NUM_BYPASS-1:0]            byp_valid_i,
    input  logic [NUM_BYPASS*ROB_IDX_W-1:0]  byp_tag_i,
    input  logic [NUM_BYPASS*32-1:0]         byp_data_i,
    input  logic                             wb_valid_i,
    input  logic [ROB_IDX_W-1:0]             wb_tag_i,
    input  logic [31:0]                      wb_data_i,
    input  logic                             commit_valid_i,
    input  logic                             commit_we_i,
    input  logic [4:0]                       commit_rd_i,
    input  logic [ROB_IDX_W-1:0]             commit_tag_i,
    output logic [31:0]                      rs1_data_o,
    output logic [31:0]                      rs2_data_o,
`ifdef RENAME_SB_PERF_EN
    output logic [31:0]                      stall_cnt_o,
`endif
    output logic                             operands_ready_o
);

    sb_entry_t ent_q [NUM_REGS];
    sb_entry_t ent_d [NUM_REGS];

    logic rs1_resolved, rs2_resolved;

    // Next-state: wb, then commit, then alloc so that alloc overrides both on the same register.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            ent_d[r] = ent_q[r];
        end
        if (flush_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                ent_d[r].busy = 1'b0;
                ent_d[r].done = 1'b0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wb_valid_i && ent_q[r].busy && !ent_q[r].done &&
                    ent_q[r].tag == rob_idx_t'(wb_tag_i)) begin
                    ent_d[r].done  = 1'b1;
                    ent_d[r].value = wb_data_i;
                end
                // A stale commit (a newer producer has since been allocated) fails the tag test.
                if (commit_valid_i && commit_we_i && commit_rd_i == reg_addr_t'(r) &&
                    ent_q[r].busy && ent_q[r].tag == rob_idx_t'(commit_tag_i)) begin
                    ent_d[r].busy = 1'b0;
                    ent_d[r].done = 1'b0;
                end
                if (alloc_valid_i && alloc_we_i && alloc_rd_i == reg_addr_t'(r)) begin
                    ent_d[r].busy = 1'b1;
                    ent_d[r].done = 1'b0;
                    ent_d[r].tag  = rob_idx_t'(alloc_tag_i);
                end
            end
        end
        // x0 has no producer ever.
        ent_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                ent_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                ent_q[r] <= ent_d[r];
            end
        end
    end

    // Lookup uses registered state only, so an instruction never sees its own alloc.
    rename_sb_fwd_mux #(.NUM_BYPASS(NUM_BYPASS), .ROB_IDX_W(ROB_IDX_W)) u_fwd_rs1 (
        .entry_i     (ent_q[rs1_addr_i]),
        .rf_data_i   ((rs1_addr_i == 5'd0) ? 32'd0 : rf_rs1_data_i),
        .byp_valid_i (byp_valid_i),
        .byp_tag_i   (byp_tag_i),
        .byp_data_i  (byp_data_i),
        .data_o      (rs1_data_o),
        .resolved_o  (rs1_resolved)
    );

    rename_sb_fwd_mux #(.NUM_BYPASS(NUM_BYPASS), .ROB_IDX_W(ROB_IDX_W)) u_fwd_rs2 (
        .entry_i     (ent_q[rs2_addr_i]),
        .rf_data_i   ((rs2_addr_i == 5'd0) ? 32'd0 : rf_rs2_data_i),
        .byp_valid_i (byp_valid_i),
        .byp_tag_i   (byp_tag_i),
        .byp_data_i  (byp_data_i),
        .data_o      (rs2_data_o),
        .resolved_o  (rs2_resolved)
    );

    assign operands_ready_o = rs1_resolved && rs2_resolved;

`ifdef RENAME_SB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Flush does not clear the count; only reset does.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (alloc_valid_i && !operands_ready_o && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rename_scoreboard.sv
// Directed self-checking bench for rename_scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
// Builds with or without RENAME_SB_PERF_EN.
module tb_rename_scoreboard;

    localparam int NB  = 2;
    localparam int TW  = 3;
    localparam logic [31:0] RF1 = 32'hAAAA_0001;
    localparam logic [31:0] RF2 = 32'hBBBB_0002;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              flush_i;
    logic              alloc_valid_i, alloc_we_i;
    logic [4:0]        alloc_rd_i;
    logic [TW-1:0]     alloc_tag_i;
    logic [4:0]        rs1_addr_i, rs2_addr_i;
    logic [31:0]       rf_rs1_data_i, rf_rs2_data_i;
    logic [NB-1:0]     byp_valid_i;
    logic [NB*TW-1:0]  byp_tag_i;
    logic [NB*32-1:0]  byp_data_i;
    logic              wb_valid_i;
    logic [TW-1:0]     wb_tag_i;
    logic [31:0]       wb_data_i;
    logic              commit_valid_i, commit_we_i;
    logic [4:0]        commit_rd_i;
    logic [TW-1:0]     commit_tag_i;
    logic [31:0]       rs1_data_o, rs2_data_o;
    logic              operands_ready_o;
`ifdef RENAME_SB_PERF_EN
    logic [31:0]       stall_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    rename_scoreboard #(.NUM_BYPASS(NB), .ROB_IDX_W(TW), .NUM_REGS(32)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .flush_i          (flush_i),
        .alloc_valid_i    (alloc_valid_i),
        .alloc_we_i       (alloc_we_i),
        .alloc_rd_i       (alloc_rd_i),
        .alloc_tag_i      (alloc_tag_i),
        .rs1_addr_i       (rs1_addr_i),
        .rs2_addr_i       (rs2_addr_i),
        .rf_rs1_data_i    (rf_rs1_data_i),
        .rf_rs2_data_i    (rf_rs2_data_i),
        .byp_valid_i      (byp_valid_i),
        .byp_tag_i        (byp_tag_i),
        .byp_data_i       (byp_data_i),
        .wb_valid_i       (wb_valid_i),
        .wb_tag_i         (wb_tag_i),
        .wb_data_i        (wb_data_i),
        .commit_valid_i   (commit_valid_i),
        .commit_we_i      (commit_we_i),
        .commit_rd_i      (commit_rd_i),
        .commit_tag_i     (commit_tag_i),
        .rs1_data_o       (rs1_data_o),
        .rs2_data_o       (rs2_data_o),
`ifdef RENAME_SB_PERF_EN
        .stall_cnt_o      (stall_cnt_o),
`endif
        .operands_ready_o (operands_ready_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i        = 1'b0;
        alloc_valid_i  = 1'b0;
        alloc_we_i     = 1'b0;
        alloc_rd_i     = '0;
        alloc_tag_i    = '0;
        byp_valid_i    = '0;
        byp_tag_i      = '0;
        byp_data_i     = '0;
        wb_valid_i     = 1'b0;
        wb_tag_i       = '0;
        wb_data_i      = '0;
        commit_valid_i = 1'b0;
        commit_we_i    = 1'b0;
        commit_rd_i    = '0;
        commit_tag_i   = '0;
    endtask

    task automatic set_alloc(input logic [4:0] rd, input logic [TW-1:0] tag);
        alloc_valid_i = 1'b1;
        alloc_we_i    = 1'b1;
        alloc_rd_i    = rd;
        alloc_tag_i   = tag;
    endtask

    task automatic set_commit(input logic [4:0] rd, input logic [TW-1:0] tag);
        commit_valid_i = 1'b1;
        commit_we_i    = 1'b1;
        commit_rd_i    = rd;
        commit_tag_i   = tag;
    endtask

    task automatic set_byp0(input logic [TW-1:0] tag, input logic [31:0] dat);
        byp_valid_i = 2'b01;
        byp_tag_i   = {3'd0, tag};
        byp_data_i  = {32'd0, dat};
    endtask

    initial begin
        idle();
        rf_rs1_data_i = RF1;
        rf_rs2_data_i = RF2;
        rstn_i        = 1'b0;
        rs1_addr_i    = 5'd5;
        rs2_addr_i    = 5'd7;
        #12;
        // Reset state: everything from the regfile, ready.
        chk("rst_rs1", rs1_data_o, RF1);
        chk("rst_rs2", rs2_data_o, RF2);
        chk("rst_rdy", {31'd0, operands_ready_o}, 32'd1);
        rs1_addr_i = 5'd0;
        #1 chk("x0_reads_zero", rs1_data_o, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();

        // Alloc x5 tag 2; same-cycle lookup still sees the old state.
        set_alloc(5'd5, 3'd2);
        rs1_addr_i = 5'd5;
        rs2_addr_i = 5'd0;
        #1 chk("self_dep_rs1", rs1_data_o, RF1);
        chk("self_dep_rdy", {31'd0, operands_ready_o}, 32'd1);
        tick();
        idle();
        #1 chk("busy_no_byp_rdy", {31'd0, operands_ready_o}, 32'd0);
        set_byp0(3'd2, 32'h11);
        #1 chk("byp0_rs1", rs1_data_o, 32'h11);
        chk("byp0_rdy", {31'd0, operands_ready_o}, 32'd1);
        idle();

        // Both bypass ports match: port 0 wins.
        set_alloc(5'd6, 3'd3);
        tick();
        idle();
        rs1_addr_i  = 5'd6;
        byp_valid_i = 2'b11;
        byp_tag_i   = {3'd3, 3'd3};
        byp_data_i  = {32'hB, 32'hA};
        #1 chk("byp_prio_port0", rs1_data_o, 32'hA);
        byp_valid_i = 2'b10;
        #1 chk("byp_port1_only", rs1_data_o, 32'hB);
        idle();

        // Alloc x7 tag 1, writeback, stored value, then commit.
        rs1_addr_i = 5'd0;
        rs2_addr_i = 5'd7;
        set_alloc(5'd7, 3'd1);
        tick();
        idle();
        wb_valid_i = 1'b1;
        wb_tag_i   = 3'd1;
        wb_data_i  = 32'h55;
        #1 chk("wb_cycle_unresolved", {31'd0, operands_ready_o}, 32'd0);
        tick();
        idle();
        #1 chk("stored_rs2", rs2_data_o, 32'h55);
        chk("stored_rdy", {31'd0, operands_ready_o}, 32'd1);
        set_byp0(3'd1, 32'h99);
        #1 chk("stored_over_byp", rs2_data_o, 32'h55);
        idle();
        set_commit(5'd7, 3'd1);
        tick();
        idle();
        #1 chk("commit_rf_rs2", rs2_data_o, RF2);

        // Stale commit leaves the newer producer in place.
        set_alloc(5'd7, 3'd1);
        tick();
        set_alloc(5'd7, 3'd4);
        tick();
        idle();
        set_commit(5'd7, 3'd1);
        tick();
        idle();
        #1 chk("stale_commit_busy", {31'd0, operands_ready_o}, 32'd0);
        set_byp0(3'd4, 32'h44);
        #1 chk("stale_commit_tag4", rs2_data_o, 32'h44);
        set_byp0(3'd1, 32'h77);
        #1 chk("old_tag_no_match", {31'd0, operands_ready_o}, 32'd0);
        idle();

        // Alloc and commit to the same register in one cycle: alloc wins.
        set_commit(5'd7, 3'd4);
        set_alloc(5'd7, 3'd6);
        tick();
        idle();
        set_byp0(3'd6, 32'h66);
        #1 chk("alloc_wins_data", rs2_data_o, 32'h66);
        set_byp0(3'd4, 32'h40);
        #1 chk("alloc_wins_old_tag", {31'd0, operands_ready_o}, 32'd0);
        idle();

        // Flush with concurrent alloc x9: x5, x6, x7 all busy beforehand.
        flush_i = 1'b1;
        set_alloc(5'd9, 3'd5);
        tick();
        idle();
        rs1_addr_i = 5'd5;
        rs2_addr_i = 5'd6;
        #1 chk("flush_rs1_x5", rs1_data_o, RF1);
        chk("flush_rs2_x6", rs2_data_o, RF2);
        chk("flush_rdy_a", {31'd0, operands_ready_o}, 32'd1);
        rs1_addr_i = 5'd9;
        rs2_addr_i = 5'd7;
        #1 chk("flush_x9_rs1", rs1_data_o, RF1);
        chk("flush_x7_rs2", rs2_data_o, RF2);
        chk("flush_rdy_b", {31'd0, operands_ready_o}, 32'd1);

        // Mid-operation reset discards a done entry and a pending one.
        set_alloc(5'd10, 3'd2);
        tick();
        idle();
        wb_valid_i = 1'b1;
        wb_tag_i   = 3'd2;
        wb_data_i  = 32'h123;
        set_alloc(5'd11, 3'd3);
        tick();
        idle();
        rs1_addr_i = 5'd10;
        rs2_addr_i = 5'd11;
        #1 chk("pre_rst_stored", rs1_data_o, 32'h123);
        rstn_i = 1'b0;
        #1 chk("rst_mid_rs1", rs1_data_o, RF1);
        chk("rst_mid_rs2", rs2_data_o, RF2);
        chk("rst_mid_rdy", {31'd0, operands_ready_o}, 32'd1);
`ifdef RENAME_SB_PERF_EN
        chk("perf_rst_zero", stall_cnt_o, 32'd0);
`endif
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();
        set_byp0(3'd3, 32'hDEAD);
        #1 chk("post_rst_no_fwd", rs2_data_o, RF2);
        idle();

        // x0 is never busy even if decode allocates it.
        rs1_addr_i = 5'd0;
        rs2_addr_i = 5'd0;
        set_alloc(5'd0, 3'd1);
        tick();
        idle();
        #1 chk("x0_alloc_rs1", rs1_data_o, 32'd0);
        chk("x0_alloc_rdy", {31'd0, operands_ready_o}, 32'd1);

`ifdef RENAME_SB_PERF_EN
        chk("perf_after_rst", stall_cnt_o, 32'd0);
        set_alloc(5'd12, 3'd1);
        tick();
        idle();
        rs1_addr_i    = 5'd12;
        alloc_valid_i = 1'b1;
        tick();
        chk("perf_one", stall_cnt_o, 32'd1);
        tick();
        tick();
        chk("perf_three", stall_cnt_o, 32'd3);
        alloc_valid_i = 1'b0;
        tick();
        chk("perf_no_alloc", stall_cnt_o, 32'd3);
        alloc_valid_i = 1'b1;
        set_byp0(3'd1, 32'h5);
        tick();
        chk("perf_ready_alloc", stall_cnt_o, 32'd3);
        idle();
        alloc_valid_i = 1'b1;
        flush_i       = 1'b1;
        tick();
        idle();
        chk("perf_flush_keeps", stall_cnt_o, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
